// File: rtl/acc_exec_ctrl.sv
// Accumulator / execute sequencer in front of alu_nbit: accepts one op at a time,
// fetches or stores the memory operand, drives the ALU and writes back acc and flags.
//
// state | meaning
// IDLE  | op_ready high, waiting for op_valid
// MEMRD | read request outstanding, waiting for mem_ack
// MEMWR | write request (acc) outstanding, waiting for mem_ack
// EXEC  | ALU lines driven for one cycle, result captured at the edge
// DONE  | done (and err for illegal opcodes) high for one cycle
module acc_exec_ctrl #(
   parameter int N      = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid_i,
   output logic              op_ready_o,
   input  logic [3:0]        op_code_i,
   input  logic [ADDR_W-1:0] op_addr_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [N-1:0]      mem_wdata_o,
   input  logic [N-1:0]      mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [N-1:0]      alu_in0_o,
   output logic [N-1:0]      alu_in1_o,
   output logic [2:0]        alu_ctrl_o,
   output logic              alu_cin_o,
   input  logic [N-1:0]      alu_result_i,
   input  logic              alu_cout_i,
   input  logic              alu_v_i,
   output logic [N-1:0]      acc_o,
   output logic              flag_c_o,
   output logic              flag_v_o,
   output logic              flag_z_o,
   output logic              flag_n_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_STA = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_ADC = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_AND = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_CLC = 4'd9;

   localparam logic [2:0] CTRL_ADD = 3'b000;
   localparam logic [2:0] CTRL_SUB = 3'b001;
   localparam logic [2:0] CTRL_OR  = 3'b010;
   localparam logic [2:0] CTRL_AND = 3'b100;
   localparam logic [2:0] CTRL_NOT = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MEMRD = 3'd1,
      S_MEMWR = 3'd2,
      S_EXEC  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q;
   logic [3:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [N-1:0]        acc_q;
   logic [N-1:0]        operand_q;
   logic                flag_c_q, flag_v_q, flag_z_q, flag_n_q;
   logic                op_ready_q, mem_req_q, mem_we_q, done_q, err_q;
   logic [2:0]          alu_ctrl_q;
   logic                alu_cin_q;
   logic [2:0]          exec_ctrl_d;
   logic                exec_cin_d;

   // ALU setup for ops that reach EXEC through MEMRD; op_q is already latched there.
   always_comb begin
      exec_ctrl_d = CTRL_ADD;
      exec_cin_d  = 1'b0;
      case (op_q)
         OP_ADC: exec_cin_d = flag_c_q;
         OP_SUB: begin
            exec_ctrl_d = CTRL_SUB;
            exec_cin_d  = 1'b1;
         end
         OP_OR:   exec_ctrl_d = CTRL_OR;
         OP_AND:  exec_ctrl_d = CTRL_AND;
         OP_NOT:  exec_ctrl_d = CTRL_NOT;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= OP_NOP;
         addr_q     <= '0;
         acc_q      <= '0;
         operand_q  <= '0;
         flag_c_q   <= 1'b0;
         flag_v_q   <= 1'b0;
         flag_z_q   <= 1'b1;
         flag_n_q   <= 1'b0;
         op_ready_q <= 1'b1;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         alu_ctrl_q <= CTRL_ADD;
         alu_cin_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (op_valid_i) begin
                  op_q       <= op_code_i;
                  addr_q     <= op_addr_i;
                  op_ready_q <= 1'b0;
                  case (op_code_i)
                     OP_LDA, OP_ADD, OP_ADC, OP_SUB, OP_OR, OP_AND: begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_MEMRD;
                     end
                     OP_STA: begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        state_q   <= S_MEMWR;
                     end
                     OP_NOT: begin
                        alu_ctrl_q <= CTRL_NOT;
                        alu_cin_q  <= 1'b0;
                        state_q    <= S_EXEC;
                     end
                     OP_CLC: begin
                        flag_c_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                     end
                     OP_NOP: begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                     default: begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                     end
                  endcase
               end
            end
            S_MEMRD: begin
               if (mem_ack_i) begin
                  operand_q <= mem_rdata_i;
                  mem_req_q <= 1'b0;
                  if (op_q == OP_LDA) begin
                     acc_q    <= mem_rdata_i;
                     flag_z_q <= (mem_rdata_i == '0);
                     flag_n_q <= mem_rdata_i[N-1];
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     alu_ctrl_q <= exec_ctrl_d;
                     alu_cin_q  <= exec_cin_d;
                     state_q    <= S_EXEC;
                  end
               end
            end
            S_MEMWR: begin
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_EXEC: begin
               acc_q    <= alu_result_i;
               flag_z_q <= (alu_result_i == '0);
               flag_n_q <= alu_result_i[N-1];
               // Only arithmetic ops own C and V; logic ops leave them alone.
               if (op_q == OP_ADD || op_q == OP_ADC || op_q == OP_SUB) begin
                  flag_c_q <= alu_cout_i;
                  flag_v_q <= alu_v_i;
               end
               alu_ctrl_q <= CTRL_ADD;
               alu_cin_q  <= 1'b0;
               done_q     <= 1'b1;
               state_q    <= S_DONE;
            end
            S_DONE: begin
               op_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: begin
               op_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign op_ready_o  = op_ready_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = acc_q;
   assign alu_in0_o   = acc_q;
   assign alu_in1_o   = operand_q;
   assign alu_ctrl_o  = alu_ctrl_q;
   assign alu_cin_o   = alu_cin_q;
   assign acc_o       = acc_q;
   assign flag_c_o    = flag_c_q;
   assign flag_v_o    = flag_v_q;
   assign flag_z_o    = flag_z_q;
   assign flag_n_o    = flag_n_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule
